list_writer: RTL

- Builder for the linked-list memory image that the sum datapath walks. It is the write side of the same list format.
- Accepts 32-bit values over a valid/ready handshake and appends each value as a node at the list tail.
- Drives a single synchronous write port of the list RAM.
- Memory format:
  - mem[0] holds the head pointer.
  - A node at address p stores its next pointer in mem[p] and its value in mem[p+1].
  - A next pointer of 0 terminates the list.

---
 rtl/list_writer_pkg.sv | 27 ++
 rtl/list_wr_port.sv | 70 +++++++
 rtl/list_writer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/list_writer_pkg.sv
// Shared definitions for the linked-list image writer: default widths,
// the fixed memory layout constants and the writer FSM state encoding.
package list_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int ADDR_W_DEF  = 4;

  // mem[HEAD_ADDR] holds the head pointer; nodes are NODE_STRIDE words apart
  // starting at FIRST_NODE. A node at p keeps next in mem[p], value in mem[p+1].
  localparam int HEAD_ADDR   = 0;
  localparam int FIRST_NODE  = 2;
  localparam int NODE_STRIDE = 2;

  typedef enum logic [2:0] {
    INIT   = 3'd0,
    IDLE   = 3'd1,
    WR_VAL = 3'd2,
    WR_NXT = 3'd3,
    LINK   = 3'd4
  } state_e;

  // Node slots are 2, 4, ... 2^aw-2, so one slot pair is lost to the head.
  function automatic int max_nodes(input int aw);
    return (1 << (aw - 1)) - 1;
  endfunction

endpackage

// File: rtl/list_wr_port.sv
// Registered write-port mux for the list RAM. It is fed the state the FSM is
// about to enter, so each write appears on mem_* in the same cycle the FSM
// sits in the corresponding write state.
module list_wr_port
  import list_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  state_e            nxt_state_i,
  input  logic [ADDR_W-1:0] new_node_i,
  input  logic [DATA_W-1:0] new_value_i,
  input  logic [ADDR_W-1:0] node_i,
  input  logic [ADDR_W-1:0] tail_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o
);

  logic              mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;

  // Decode the upcoming state into one write; address/data idle at zero.
  always_comb begin
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    case (nxt_state_i)
      INIT: begin
        mem_we_d   = 1'b1;
        mem_addr_d = ADDR_W'(HEAD_ADDR);
      end
      // Value word first; the node is only reachable after LINK.
      WR_VAL: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = new_node_i + ADDR_W'(1);
        mem_wdata_d = new_value_i;
      end
      // New node terminates the list.
      WR_NXT: begin
        mem_we_d   = 1'b1;
        mem_addr_d = node_i;
      end
      // Old tail (or the head pointer when tail is 0) now points at the node.
      LINK: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = tail_i;
        mem_wdata_d = DATA_W'(node_i);
      end
      default: ;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      mem_we_o    <= mem_we_d;
      mem_addr_o  <= mem_addr_d;
      mem_wdata_o <= mem_wdata_d;
    end
  end

endmodule

// File: rtl/list_writer.sv
// list_writer: appends 32-bit values as nodes at the tail of a linked list
// held in a single-write-port RAM. Optional feature macro
// LIST_WRITER_SUM_EN adds sum_out, the running total of all listed values.
//
// Handshake: a value transfers on a rising edge where in_valid and in_ready
// are both high and start is low. in_ready is registered, only ever high in
// IDLE when the list is not full, and drops for the 3 write cycles after each
// transfer. start in IDLE wins over in_valid; start elsewhere is ignored.
module list_writer
  import list_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              full,
`ifdef LIST_WRITER_SUM_EN
  output logic [DATA_W-1:0] sum_out,
`endif
  output logic [ADDR_W-1:0] node_count
);

  localparam logic [ADDR_W-1:0] MAX_CNT = ADDR_W'(max_nodes(ADDR_W));
  localparam logic [ADDR_W-1:0] STRIDE  = ADDR_W'(NODE_STRIDE);
  localparam logic [ADDR_W-1:0] FIRST   = ADDR_W'(FIRST_NODE);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] tail_q, tail_d;
  logic [ADDR_W-1:0] alloc_q, alloc_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [ADDR_W-1:0] node_q, node_d;
  logic              in_ready_q, busy_q, full_q;
  logic              accept;
`ifdef LIST_WRITER_SUM_EN
  logic [DATA_W-1:0] value_q, value_d;
  logic [DATA_W-1:0] sum_q, sum_d;
`endif

  assign accept = (state_q == IDLE) && !start && in_valid && in_ready_q;

  // Next state and list bookkeeping.
  always_comb begin
    state_d = state_q;
    tail_d  = tail_q;
    alloc_d = alloc_q;
    count_d = count_q;
    node_d  = node_q;
`ifdef LIST_WRITER_SUM_EN
    value_d = value_q;
    sum_d   = sum_q;
`endif
    case (state_q)
      // Entered either from reset (no write yet issued) or from IDLE with
      // the head write already on the port; leave once that write is out.
      INIT: begin
        if (mem_we) state_d = IDLE;
      end
      IDLE: begin
        if (start) begin
          state_d = INIT;
          tail_d  = '0;
          alloc_d = FIRST;
          count_d = '0;
`ifdef LIST_WRITER_SUM_EN
          sum_d   = '0;
`endif
        end else if (accept) begin
          state_d = WR_VAL;
          node_d  = alloc_q;
`ifdef LIST_WRITER_SUM_EN
          value_d = in_data;
`endif
        end
      end
      WR_VAL: state_d = WR_NXT;
      WR_NXT: state_d = LINK;
      LINK: begin
        state_d = IDLE;
        tail_d  = node_q;
        alloc_d = alloc_q + STRIDE;
        count_d = count_q + ADDR_W'(1);
`ifdef LIST_WRITER_SUM_EN
        sum_d   = sum_q + value_q;
`endif
      end
      default: state_d = INIT;
    endcase
  end

  // State, counters and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= INIT;
      tail_q     <= '0;
      alloc_q    <= FIRST;
      count_q    <= '0;
      node_q     <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b1;
      full_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tail_q     <= tail_d;
      alloc_q    <= alloc_d;
      count_q    <= count_d;
      node_q     <= node_d;
      in_ready_q <= (state_d == IDLE) && (count_d != MAX_CNT);
      busy_q     <= (state_d != IDLE);
      full_q     <= (count_d == MAX_CNT);
    end
  end

`ifdef LIST_WRITER_SUM_EN
  // Running total of the values currently linked into the list.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= '0;
      sum_q   <= '0;
    end else begin
      value_q <= value_d;
      sum_q   <= sum_d;
    end
  end

  assign sum_out = sum_q;
`endif

  assign in_ready   = in_ready_q;
  assign busy       = busy_q;
  assign full       = full_q;
  assign node_count = count_q;

  list_wr_port #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_port (
    .clk        (clk),
    .rst        (rst),
    .nxt_state_i(state_d),
    .new_node_i (alloc_q),
    .new_value_i(in_data),
    .node_i     (node_q),
    .tail_i     (tail_q),
    .mem_we_o   (mem_we),
    .mem_addr_o (mem_addr),
    .mem_wdata_o(mem_wdata)
  );

endmodule
